// File: rtl/pin_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pin_ctrl_pkg
//   Shared types and width helpers for the PIN attempt controller.
//   - pin_state_e : controller state encoding
//   - tries_width : bits needed to hold 0..max_tries
//   - timer_width : bits needed by the shared cycle timer
// -----------------------------------------------------------------------------
package pin_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT     = 3'd2,
        UNLOCKED = 3'd3,
        LOCKED   = 3'd4,
        FAULT    = 3'd5
    } pin_state_e;

    localparam int DEF_MAX_TRIES    = 3;
    localparam int DEF_LOCK_CYCLES  = 1000;
    localparam int DEF_UNLOCK_HOLD  = 50;
    localparam int DEF_RESP_TIMEOUT = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic int tries_width(input int max_tries);
        return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
    endfunction

    function automatic int timer_width(input int lock_cycles, input int unlock_hold,
                                       input int resp_timeout);
        return $clog2(max3(lock_cycles, unlock_hold, resp_timeout) + 1);
    endfunction

endpackage

// File: rtl/pin_cycle_timer.sv
// -----------------------------------------------------------------------------
// pin_cycle_timer
//   Single down-counter shared by every timed state of the controller.
//   A load of N makes o_expired high in the N-th cycle after the load, so the
//   owning state lasts exactly N cycles. The count saturates at zero.
// Ports
//   clk           in  1      system clock
//   reset         in  1      synchronous active-low reset (count -> 0)
//   i_load        in  1      load i_load_value on this edge
//   i_load_value  in  WIDTH  cycles the next timed state should last
//   o_expired     out 1      current cycle is the last one of the timed window
// -----------------------------------------------------------------------------
module pin_cycle_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // Expiry is flagged while the count is 1 so the state exits on the edge
    // where the count reaches 0; a count already at 0 also reads as expired.
    assign o_expired = (r_count <= WIDTH'(1));

endmodule

// File: rtl/pin_attempt_controller.sv
// -----------------------------------------------------------------------------
// pin_attempt_controller
//   Sequences PIN entry attempts around the debit-PIN checker: edge-detects
//   the submit button, pulses the checker, waits for a verdict, counts
//   consecutive failures, enforces a timed lockout, holds an unlocked window
//   and clears the checker between attempts. Every output is registered.
// Ports
//   clk            in   1   system clock, rising edge
//   reset          in   1   synchronous active-low reset
//   user_submit    in   1   submit button level (pre-synchronised)
//   user_cancel    in   1   ends the unlocked window early
//   chk_waiting    in   1   checker ready to accept a submit
//   chk_correct    in   1   checker verdict: PIN matched
//   chk_incorrect  in   1   checker verdict: PIN mismatched
//   chk_bug        in   1   checker internal error
//   chk_submit     out  1   one-cycle submit pulse to the checker
//   chk_clear      out  1   one-cycle clear pulse to the checker
//   unlocked       out  1   access granted
//   locked         out  1   lockout in progress
//   fault          out  1   sticky error, left only through reset
//   busy           out  1   attempt in flight
//   tries_left     out  TW  remaining attempts before lockout
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a submit edge (ignored in the clear cycle)
// ISSUE    | chk_submit high for this single cycle, arms response timer
// WAIT     | waiting for the checker verdict under the response timer
// UNLOCKED | access granted until hold timer expires or user cancels
// LOCKED   | too many failures, submits ignored until lock timer expires
// FAULT    | checker misbehaved; only reset leaves this state
// -----------------------------------------------------------------------------
module pin_attempt_controller
    import pin_ctrl_pkg::*;
#(
    parameter  int MAX_TRIES    = DEF_MAX_TRIES,
    parameter  int LOCK_CYCLES  = DEF_LOCK_CYCLES,
    parameter  int UNLOCK_HOLD  = DEF_UNLOCK_HOLD,
    parameter  int RESP_TIMEOUT = DEF_RESP_TIMEOUT,
    localparam int TW           = tries_width(MAX_TRIES),
    localparam int CW           = timer_width(LOCK_CYCLES, UNLOCK_HOLD, RESP_TIMEOUT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          user_submit,
    input  logic          user_cancel,
    input  logic          chk_waiting,
    input  logic          chk_correct,
    input  logic          chk_incorrect,
    input  logic          chk_bug,
    output logic          chk_submit,
    output logic          chk_clear,
    output logic          unlocked,
    output logic          locked,
    output logic          fault,
    output logic          busy,
    output logic [TW-1:0] tries_left
);

    pin_state_e    r_state;
    pin_state_e    w_state_nxt;

    logic [TW-1:0] r_fail_cnt;
    logic [TW-1:0] w_fail_nxt;
    logic [TW-1:0] w_fail_inc;
    logic          r_submit_prev;
    logic          w_submit_edge;

    logic          w_clear_nxt;
    logic          w_tmr_load;
    logic [CW-1:0] w_tmr_value;
    logic          w_tmr_expired;

    logic          r_chk_submit;
    logic          r_chk_clear;
    logic          r_unlocked;
    logic          r_locked;
    logic          r_fault;
    logic          r_busy;
    logic [TW-1:0] r_tries_left;

    pin_cycle_timer #(
        .WIDTH        (CW)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .o_expired    (w_tmr_expired)
    );

    assign w_submit_edge = user_submit & ~r_submit_prev;
    assign w_fail_inc    = r_fail_cnt + TW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = r_fail_cnt;
        w_clear_nxt = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;

        case (r_state)
            IDLE: begin
                // r_chk_clear marks the first cycle back in IDLE; a press that
                // lands there is dropped. A press while the checker is not
                // ready is dropped as well; presses are never queued.
                if (w_submit_edge && !r_chk_clear && chk_waiting) begin
                    w_state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                w_state_nxt = WAIT;
                w_tmr_load  = 1'b1;
                w_tmr_value = CW'(RESP_TIMEOUT);
            end

            WAIT: begin
                // A verdict in the last allowed cycle still wins over timeout.
                if (chk_correct && chk_incorrect) begin
                    w_state_nxt = FAULT;
                end else if (chk_correct) begin
                    w_state_nxt = UNLOCKED;
                    w_fail_nxt  = '0;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = CW'(UNLOCK_HOLD);
                end else if (chk_incorrect) begin
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc == TW'(MAX_TRIES)) begin
                        w_state_nxt = LOCKED;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = CW'(LOCK_CYCLES);
                    end else begin
                        w_state_nxt = IDLE;
                        w_clear_nxt = 1'b1;
                    end
                end else if (w_tmr_expired) begin
                    w_state_nxt = FAULT;
                end
            end

            UNLOCKED: begin
                if (w_tmr_expired || user_cancel) begin
                    w_state_nxt = IDLE;
                    w_clear_nxt = 1'b1;
                end
            end

            LOCKED: begin
                if (w_tmr_expired) begin
                    w_state_nxt = IDLE;
                    w_clear_nxt = 1'b1;
                    w_fail_nxt  = '0;
                end
            end

            FAULT: begin
                w_state_nxt = FAULT;
            end

            default: begin
                w_state_nxt = FAULT;
            end
        endcase

        // Checker error overrides any transition computed above.
        if (chk_bug) begin
            w_state_nxt = FAULT;
            w_fail_nxt  = r_fail_cnt;
            w_clear_nxt = 1'b0;
            w_tmr_load  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_fail_cnt    <= '0;
            r_submit_prev <= 1'b1;     // a button held through reset must not fire
        end else begin
            r_state       <= w_state_nxt;
            r_fail_cnt    <= w_fail_nxt;
            r_submit_prev <= user_submit;
        end
    end

    // Outputs are decoded from the next state so they line up with the state
    // register instead of lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_chk_submit <= 1'b0;
            r_chk_clear  <= 1'b0;
            r_unlocked   <= 1'b0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
            r_busy       <= 1'b0;
            r_tries_left <= TW'(MAX_TRIES);
        end else begin
            r_chk_submit <= (w_state_nxt == ISSUE);
            r_chk_clear  <= w_clear_nxt;
            r_unlocked   <= (w_state_nxt == UNLOCKED);
            r_locked     <= (w_state_nxt == LOCKED);
            r_fault      <= (w_state_nxt == FAULT);
            r_busy       <= (w_state_nxt == ISSUE) || (w_state_nxt == WAIT);
            r_tries_left <= (w_state_nxt == FAULT) ? '0 : (TW'(MAX_TRIES) - w_fail_nxt);
        end
    end

    assign chk_submit = r_chk_submit;
    assign chk_clear  = r_chk_clear;
    assign unlocked   = r_unlocked;
    assign locked     = r_locked;
    assign fault      = r_fault;
    assign busy       = r_busy;
    assign tries_left = r_tries_left;

endmodule

// File: tb/tb_pin_attempt_controller.sv
// -----------------------------------------------------------------------------
// tb_pin_attempt_controller
//   Directed bench for pin_attempt_controller with short timers
//   (MAX_TRIES=3, LOCK_CYCLES=20, UNLOCK_HOLD=5, RESP_TIMEOUT=4).
//   The bench plays the checker itself. Inputs change 1 time unit after a
//   rising edge and outputs are read at that same point.
// -----------------------------------------------------------------------------
module tb_pin_attempt_controller;

    logic       clk;
    logic       reset;
    logic       user_submit;
    logic       user_cancel;
    logic       chk_waiting;
    logic       chk_correct;
    logic       chk_incorrect;
    logic       chk_bug;
    logic       chk_submit;
    logic       chk_clear;
    logic       unlocked;
    logic       locked;
    logic       fault;
    logic       busy;
    logic [1:0] tries_left;

    int n_checks = 0;
    int n_errors = 0;

    pin_attempt_controller #(
        .MAX_TRIES     (3),
        .LOCK_CYCLES   (20),
        .UNLOCK_HOLD   (5),
        .RESP_TIMEOUT  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .user_submit   (user_submit),
        .user_cancel   (user_cancel),
        .chk_waiting   (chk_waiting),
        .chk_correct   (chk_correct),
        .chk_incorrect (chk_incorrect),
        .chk_bug       (chk_bug),
        .chk_submit    (chk_submit),
        .chk_clear     (chk_clear),
        .unlocked      (unlocked),
        .locked        (locked),
        .fault         (fault),
        .busy          (busy),
        .tries_left    (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic sub, input logic clr, input logic unl,
                        input logic lck, input logic flt, input logic bsy, input logic [1:0] tl);
        check({tag, ".chk_submit"}, chk_submit, sub);
        check({tag, ".chk_clear"},  chk_clear,  clr);
        check({tag, ".unlocked"},   unlocked,   unl);
        check({tag, ".locked"},     locked,     lck);
        check({tag, ".fault"},      fault,      flt);
        check({tag, ".busy"},       busy,       bsy);
        check({tag, ".tries_left"}, tries_left, tl);
    endtask

    initial begin
        reset         = 1'b0;
        user_submit   = 1'b0;
        user_cancel   = 1'b0;
        chk_waiting   = 1'b1;
        chk_correct   = 1'b0;
        chk_incorrect = 1'b0;
        chk_bug       = 1'b0;
        tick(2);
        outs("reset", 0, 0, 0, 0, 0, 0, 2'd3);

        reset = 1'b1;
        tick(1);
        outs("idle", 0, 0, 0, 0, 0, 0, 2'd3);

        // Correct verdict two cycles after the submit pulse.
        user_submit = 1'b1;
        tick(1);
        outs("t1_issue", 1, 0, 0, 0, 0, 1, 2'd3);
        user_submit = 1'b0;
        tick(1);
        outs("t1_wait", 0, 0, 0, 0, 0, 1, 2'd3);
        tick(1);
        chk_correct = 1'b1;
        tick(1);
        chk_correct = 1'b0;
        outs("t1_unlock", 0, 0, 1, 0, 0, 0, 2'd3);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t1_hold", unlocked, 1);
        end
        tick(1);
        outs("t1_relock", 0, 1, 0, 0, 0, 0, 2'd3);
        tick(1);
        outs("t1_idle", 0, 0, 0, 0, 0, 0, 2'd3);

        // Three incorrect verdicts lead to lockout.
        for (int a = 1; a <= 3; a++) begin
            user_submit = 1'b1;
            tick(1);
            check("t2_submit", chk_submit, 1);
            user_submit = 1'b0;
            tick(1);
            chk_incorrect = 1'b1;
            tick(1);
            chk_incorrect = 1'b0;
            check("t2_tries", tries_left, 3 - a);
            if (a < 3) begin
                check("t2_clear", chk_clear, 1);
                check("t2_not_locked", locked, 0);
            end else begin
                check("t2_locked", locked, 1);
                check("t2_no_clear", chk_clear, 0);
            end
            if (a == 1) begin
                // Press landing in the clear cycle is dropped.
                user_submit = 1'b1;
                tick(1);
                check("t2_edge_in_clear", chk_submit, 0);
                check("t2_edge_in_clear_busy", busy, 0);
                user_submit = 1'b0;
                tick(1);
            end else if (a == 2) begin
                tick(1);
            end
        end
        for (int i = 0; i < 19; i++) begin
            user_submit = (i % 2 == 0);
            tick(1);
            check("t2_lock_hold", locked, 1);
            check("t2_lock_no_submit", chk_submit, 0);
        end
        user_submit = 1'b0;
        tick(1);
        outs("t2_lock_end", 0, 1, 0, 0, 0, 0, 2'd3);
        tick(1);
        outs("t2_idle", 0, 0, 0, 0, 0, 0, 2'd3);

        // Cancel in the second unlocked cycle.
        user_submit = 1'b1;
        tick(1);
        user_submit = 1'b0;
        tick(1);
        chk_correct = 1'b1;
        tick(1);
        chk_correct = 1'b0;
        check("t6_unl_c1", unlocked, 1);
        tick(1);
        check("t6_unl_c2", unlocked, 1);
        user_cancel = 1'b1;
        tick(1);
        user_cancel = 1'b0;
        outs("t6_cancel", 0, 1, 0, 0, 0, 0, 2'd3);
        tick(1);
        check("t6_clear_done", chk_clear, 0);

        // Reset while waiting for a verdict.
        user_submit = 1'b1;
        tick(1);
        user_submit = 1'b0;
        tick(1);
        check("t6_in_wait", busy, 1);
        reset = 1'b0;
        tick(1);
        outs("t6_reset", 0, 0, 0, 0, 0, 0, 2'd3);

        // Button held across reset release must not fire.
        user_submit = 1'b1;
        tick(1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t5_held_submit", chk_submit, 0);
            check("t5_held_busy", busy, 0);
        end
        user_submit = 1'b0;
        tick(1);
        user_submit = 1'b1;
        tick(1);
        check("t5_press", chk_submit, 1);
        user_submit = 1'b0;
        tick(1);
        check("t5_wait", busy, 1);

        // Contradictory verdict.
        chk_correct   = 1'b1;
        chk_incorrect = 1'b1;
        tick(1);
        chk_correct   = 1'b0;
        chk_incorrect = 1'b0;
        outs("t4_both", 0, 0, 0, 0, 1, 0, 2'd0);
        tick(1);
        check("t4_both_sticky", fault, 1);

        // No verdict: four waiting cycles, then fault.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        user_submit = 1'b1;
        tick(1);
        check("t3_issue", chk_submit, 1);
        user_submit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t3_wait_fault", fault, 0);
            check("t3_wait_busy", busy, 1);
        end
        tick(1);
        outs("t3_timeout", 0, 0, 0, 0, 1, 0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            user_submit = (i % 2 == 0);
            tick(1);
            check("t3_sticky", fault, 1);
            check("t3_sticky_submit", chk_submit, 0);
        end
        user_submit = 1'b0;

        // Checker bug while idle.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        check("t4_pre_bug", fault, 0);
        chk_bug = 1'b1;
        tick(1);
        chk_bug = 1'b0;
        outs("t4_bug", 0, 0, 0, 0, 1, 0, 2'd0);
        tick(1);
        check("t4_bug_sticky", fault, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
